// File: rtl/rtype_ctrl_pkg.sv
// Shared constants for the R-type control sequencer: opcode/funct7 encodings,
// ALU operation codes (also used by the ALU) and the sequencer state encoding.
package rtype_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    TRAP   = 3'd4
  } state_t;

  // alt selects the funct7=0100000 variant (SUB/SRA); legality is checked separately
  function automatic logic [3:0] alu_code_of(input logic [2:0] funct3, input logic alt);
    logic [3:0] code;
    case (funct3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rtype_control_unit_if.sv
// Instruction handshake between an instruction source (master) and the
// R-type control sequencer (slave).
interface rtype_control_unit_if #(parameter int INSTR_W = 32) ();
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/rtype_decoder.sv
// Combinational RV32I R-type field extraction, ALU code lookup and legality check.
module rtype_decoder
  import rtype_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  alu_code,
  output logic        legal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  always_comb begin
    opcode   = instr[6:0];
    funct3   = instr[14:12];
    funct7   = instr[31:25];
    rd       = instr[11:7];
    rs1      = instr[19:15];
    rs2      = instr[24:20];
    alu_code = alu_code_of(funct3, funct7 == F7_ALT);
    legal    = (opcode == OP_RTYPE) &&
               ((funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
  end

endmodule

// File: rtl/rtype_control_unit.sv
// Multi-cycle R-type control sequencer: IDLE -> DECODE -> EXEC -> WB (or TRAP).
// Optional retired-instruction counter enabled by macro CTRL_RETIRE_COUNT_EN.
//
// state  | meaning
// IDLE   | ready for an instruction, datapath controls parked at 0
// DECODE | latched instruction checked for legality
// EXEC   | rs1/rs2/alu_control driven, ALU settling, no write
// WB     | rd written (unless x0), zero_flag captured
// TRAP   | illegal encoding, one-cycle illegal_instr pulse
module rtype_control_unit
  import rtype_ctrl_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  rtype_control_unit_if.slave   bus,
  input  logic                  zero_flag,
  output logic [REG_ADDR_W-1:0] read_reg_num1,
  output logic [REG_ADDR_W-1:0] read_reg_num2,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  regwrite,
  output logic                  illegal_instr,
  output logic                  last_zero,
  output logic [31:0]           retire_count
);

  state_t             state;
  logic [INSTR_W-1:0] instr_q;
  logic               ready_q;
  logic [4:0]         dec_rs1, dec_rs2, dec_rd;
  logic [3:0]         dec_alu;
  logic               dec_legal;

  rtype_decoder u_decoder (
    .instr    (instr_q),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .alu_code (dec_alu),
    .legal    (dec_legal)
  );

  assign bus.instr_ready = ready_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      instr_q       <= '0;
      ready_q       <= 1'b1;
      read_reg_num1 <= '0;
      read_reg_num2 <= '0;
      write_reg     <= '0;
      alu_control   <= '0;
      regwrite      <= 1'b0;
      illegal_instr <= 1'b0;
      last_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid && ready_q) begin
            instr_q <= bus.instr;
            ready_q <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            read_reg_num1 <= dec_rs1;
            read_reg_num2 <= dec_rs2;
            alu_control   <= dec_alu;
            state         <= EXEC;
          end else begin
            illegal_instr <= 1'b1;
            state         <= TRAP;
          end
        end
        EXEC: begin
          write_reg <= dec_rd;
          // x0 is hardwired: the instruction still retires but nothing is written
          regwrite  <= (dec_rd != 5'd0);
          state     <= WB;
        end
        WB: begin
          last_zero     <= zero_flag;
          read_reg_num1 <= '0;
          read_reg_num2 <= '0;
          write_reg     <= '0;
          alu_control   <= '0;
          regwrite      <= 1'b0;
          ready_q       <= 1'b1;
          state         <= IDLE;
        end
        TRAP: begin
          illegal_instr <= 1'b0;
          ready_q       <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef CTRL_RETIRE_COUNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retire_q <= '0;
    end else if (state == WB) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_rtype_control_unit.sv
// Directed bench for rtype_control_unit: expected decode results queued at
// issue time and popped when the sequencer reaches EXEC/WB or TRAP.
module tb_rtype_control_unit;

  typedef struct packed {
    logic       legal;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu;
    logic       zero;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        zero_flag;
  logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
  logic [3:0]  alu_control;
  logic        regwrite, illegal_instr, last_zero;
  logic [31:0] retire_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   retire_model = 0;
  logic last_zero_exp = 1'b0;
  exp_t sb[$];

  rtype_control_unit_if #(.INSTR_W(32)) bus ();

  rtype_control_unit dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .zero_flag     (zero_flag),
    .read_reg_num1 (read_reg_num1),
    .read_reg_num2 (read_reg_num2),
    .write_reg     (write_reg),
    .alu_control   (alu_control),
    .regwrite      (regwrite),
    .illegal_instr (illegal_instr),
    .last_zero     (last_zero),
    .retire_count  (retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic z);
    exp_t e;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd = i[11:7];
    e.zero = z;
    e.legal = 1'b1;
    e.alu = 4'b0000;
    if (i[6:0] != 7'b0110011) e.legal = 1'b0;
    else begin
      case ({i[31:25], i[14:12]})
        10'b0000000_000: e.alu = 4'b0010;
        10'b0100000_000: e.alu = 4'b0110;
        10'b0000000_001: e.alu = 4'b0100;
        10'b0000000_010: e.alu = 4'b0111;
        10'b0000000_011: e.alu = 4'b1001;
        10'b0000000_100: e.alu = 4'b0011;
        10'b0000000_101: e.alu = 4'b0101;
        10'b0100000_101: e.alu = 4'b1000;
        10'b0000000_110: e.alu = 4'b0001;
        10'b0000000_111: e.alu = 4'b0000;
        default:         e.legal = 1'b0;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] rc_exp();
`ifdef CTRL_RETIRE_COUNT_EN
    return retire_model;
`else
    return 32'd0;
`endif
  endfunction

  // Issue one instruction and follow it through to the return to IDLE.
  task automatic send(input logic [31:0] i, input logic z, input bit hold, input bit gap_chk);
    int   budget;
    exp_t e;
    budget = 0;
    while (bus.instr_ready !== 1'b1 && budget < 20) begin
      @(posedge clock); #1;
      budget++;
    end
    chk("ready_wait", {31'd0, bus.instr_ready}, 32'd1);
    sb.push_back(model(i, z));
    bus.instr = i;
    bus.instr_valid = 1'b1;
    @(posedge clock);
    if (gap_chk) chk("accept_gap", cyc - last_acc, 32'd4);
    last_acc = cyc;
    #1;
    if (!hold) bus.instr_valid = 1'b0;
    chk("decode_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("decode_regwrite", {31'd0, regwrite}, 32'd0);
    @(posedge clock); #1;
    e = sb.pop_front();
    if (e.legal) begin
      chk("exec_rs1", {27'd0, read_reg_num1}, {27'd0, e.rs1});
      chk("exec_rs2", {27'd0, read_reg_num2}, {27'd0, e.rs2});
      chk("exec_alu", {28'd0, alu_control}, {28'd0, e.alu});
      chk("exec_regwrite", {31'd0, regwrite}, 32'd0);
      chk("exec_illegal", {31'd0, illegal_instr}, 32'd0);
      zero_flag = e.zero;
      @(posedge clock); #1;
      chk("wb_rd", {27'd0, write_reg}, {27'd0, e.rd});
      chk("wb_regwrite", {31'd0, regwrite}, {31'd0, e.rd != 5'd0});
      chk("wb_rs1_hold", {27'd0, read_reg_num1}, {27'd0, e.rs1});
      chk("wb_alu_hold", {28'd0, alu_control}, {28'd0, e.alu});
      chk("wb_ready", {31'd0, bus.instr_ready}, 32'd0);
      @(posedge clock); #1;
      zero_flag = 1'b0;
      last_zero_exp = e.zero;
      retire_model++;
    end else begin
      chk("trap_illegal", {31'd0, illegal_instr}, 32'd1);
      chk("trap_regwrite", {31'd0, regwrite}, 32'd0);
      chk("trap_rs1", {27'd0, read_reg_num1}, 32'd0);
      @(posedge clock); #1;
    end
    chk("idle_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("idle_regwrite", {31'd0, regwrite}, 32'd0);
    chk("idle_illegal", {31'd0, illegal_instr}, 32'd0);
    chk("idle_write_reg", {27'd0, write_reg}, 32'd0);
    chk("last_zero", {31'd0, last_zero}, {31'd0, last_zero_exp});
    chk("retire_count", retire_count, rc_exp());
  endtask

  initial begin
    reset = 1'b0;
    zero_flag = 1'b0;
    bus.instr = 32'd0;
    bus.instr_valid = 1'b0;
    #12;
    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("rst_alu", {28'd0, alu_control}, 32'd0);
    chk("rst_last_zero", {31'd0, last_zero}, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    send(32'h002081B3, 1'b0, 1'b0, 1'b0);  // add x3,x1,x2
    send(32'h407302B3, 1'b1, 1'b0, 1'b0);  // sub x5,x6,x7, zero during WB
    send(32'h00000013, 1'b0, 1'b0, 1'b0);  // addi: illegal
    send(32'h00208033, 1'b0, 1'b0, 1'b0);  // add x0: no write, retires
    send(32'h40001033, 1'b1, 1'b0, 1'b0);  // funct7 alt with sll: illegal
    send(32'h4062D233, 1'b1, 1'b0, 1'b0);  // sra x4,x5,x6
    send(32'h0041B533, 1'b0, 1'b0, 1'b0);  // sltu x10,x3,x4
    send(32'h00F6C5B3, 1'b1, 1'b0, 1'b0);  // xor x11,x13,x15
    send(32'h01FF6FB3, 1'b0, 1'b0, 1'b0);  // or x31,x30,x31

    // reset during EXEC drops the in-flight and
    bus.instr = 32'h0020F233;
    bus.instr_valid = 1'b1;
    @(posedge clock); #1;
    bus.instr_valid = 1'b0;
    @(posedge clock); #1;
    chk("pre_rst_exec_rs1", {27'd0, read_reg_num1}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_rs1", {27'd0, read_reg_num1}, 32'd0);
    chk("mid_rst_rs2", {27'd0, read_reg_num2}, 32'd0);
    chk("mid_rst_alu", {28'd0, alu_control}, 32'd0);
    chk("mid_rst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("mid_rst_retire", retire_count, 32'd0);
    retire_model = 0;
    last_zero_exp = 1'b0;
    @(posedge clock); @(posedge clock); #3;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk("post_rst_regwrite", {31'd0, regwrite}, 32'd0);
      chk("post_rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    end

    // back-to-back with valid held high
    send(32'h002081B3, 1'b0, 1'b1, 1'b0);
    send(32'h407302B3, 1'b1, 1'b1, 1'b1);
    send(32'h0020F233, 1'b0, 1'b0, 1'b1);
    chk("b2b_retire", retire_count, rc_exp());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
